fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 133 +++++++++++++
 tb/tb_fetch_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - IF-stage fetch controller: redirect flushes, load/JALR/imem stalls, mispredict count
module fetch_ctrl #(
    parameter int FLUSH_CYCLES  = 1,
    parameter int JALR_MAX_WAIT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_en,
    input  logic       trap_happened,
    input  logic       mret_en,
    input  logic       br_taken,
    input  logic       load_hazard,
    input  logic       jalr_hazard,
    input  logic       imem_rdy,
    output logic       pc_stall,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       predt_mask,
    output logic [2:0] ctrl_state,
    output logic [7:0] mispredict_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        FLUSH = 3'd2,
        JWAIT = 3'd3,
        MWAIT = 3'd4
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
    localparam logic [2:0] WAIT_MAX   = 3'(JALR_MAX_WAIT);

    state_t     state, state_nxt;
    logic [2:0] flush_cnt, flush_cnt_nxt;
    logic [2:0] wait_cnt, wait_cnt_nxt;
    logic       redirect;

    assign redirect   = trap_happened | mret_en | br_taken;
    assign ctrl_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            flush_cnt      <= 3'd0;
            wait_cnt       <= 3'd0;
            mispredict_cnt <= 8'd0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            wait_cnt  <= wait_cnt_nxt;
            if (cpu_en && br_taken && mispredict_cnt != 8'hFF)
                mispredict_cnt <= mispredict_cnt + 8'd1;
        end
    end

    always_comb begin
        pc_stall      = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        predt_mask    = 1'b0;
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        wait_cnt_nxt  = wait_cnt;

        if (state == IDLE || !cpu_en) begin
            pc_stall      = 1'b1;
            flush_cnt_nxt = 3'd0;
            wait_cnt_nxt  = 3'd0;
            state_nxt     = (state == IDLE && cpu_en) ? RUN : IDLE;
        end else if (redirect) begin
            // A redirect while already flushing restarts the bubble count.
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            state_nxt     = FLUSH;
            flush_cnt_nxt = FLUSH_LOAD;
            wait_cnt_nxt  = 3'd0;
        end else begin
            unique case (state)
                RUN: begin
                    if (load_hazard) begin
                        pc_stall    = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (jalr_hazard) begin
                        pc_stall     = 1'b1;
                        state_nxt    = JWAIT;
                        wait_cnt_nxt = 3'd0;
                    end else if (!imem_rdy) begin
                        pc_stall    = 1'b1;
                        if_id_flush = 1'b1;
                        state_nxt   = MWAIT;
                    end
                end
                FLUSH: begin
                    if_id_flush   = 1'b1;
                    predt_mask    = 1'b1;
                    flush_cnt_nxt = flush_cnt - 3'd1;
                    if (flush_cnt <= 3'd1) begin
                        flush_cnt_nxt = 3'd0;
                        state_nxt     = imem_rdy ? RUN : MWAIT;
                    end
                end
                JWAIT: begin
                    if (load_hazard) begin
                        pc_stall    = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (!jalr_hazard) begin
                        state_nxt    = RUN;
                        wait_cnt_nxt = 3'd0;
                    end else if (wait_cnt == WAIT_MAX) begin
                        // Operand never arrived: fall through to pc+4 once.
                        predt_mask   = 1'b1;
                        state_nxt    = RUN;
                        wait_cnt_nxt = 3'd0;
                    end else begin
                        pc_stall     = 1'b1;
                        wait_cnt_nxt = wait_cnt + 3'd1;
                    end
                end
                MWAIT: begin
                    if (!imem_rdy) begin
                        pc_stall    = 1'b1;
                        if_id_flush = 1'b1;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl against a behavioural model
module tb_fetch_ctrl;

    localparam int FC = 2;
    localparam int JM = 3;
    localparam int S_IDLE = 0, S_RUN = 1, S_FLUSH = 2, S_JWAIT = 3, S_MWAIT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_en = 1'b0, trap_happened = 1'b0, mret_en = 1'b0, br_taken = 1'b0;
    logic       load_hazard = 1'b0, jalr_hazard = 1'b0, imem_rdy = 1'b1;
    logic       pc_stall, if_id_flush, id_ex_flush, predt_mask;
    logic [2:0] ctrl_state;
    logic [7:0] mispredict_cnt;

    int passed = 0;
    int total  = 0;

    // model: mode, remaining bubbles, JALR wait cycles, mispredict tally
    int m_mode = S_IDLE, m_left = 0, m_wait = 0, m_mis = 0;

    fetch_ctrl #(.FLUSH_CYCLES(FC), .JALR_MAX_WAIT(JM)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_en(cpu_en), .trap_happened(trap_happened),
        .mret_en(mret_en), .br_taken(br_taken), .load_hazard(load_hazard),
        .jalr_hazard(jalr_hazard), .imem_rdy(imem_rdy), .pc_stall(pc_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .predt_mask(predt_mask),
        .ctrl_state(ctrl_state), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One clock: drive inputs, check outputs against the model, advance model at the edge.
    task automatic cycle(input logic en, input logic tr, input logic mr, input logic br,
                         input logic lh, input logic jh, input logic rdy);
        logic st, ifl, exl, msk;
        int nm, nl, nw;
        cpu_en = en; trap_happened = tr; mret_en = mr; br_taken = br;
        load_hazard = lh; jalr_hazard = jh; imem_rdy = rdy;
        st = 0; ifl = 0; exl = 0; msk = 0;
        nm = m_mode; nl = m_left; nw = m_wait;
        if (m_mode == S_IDLE || !en) begin
            st = 1; nl = 0; nw = 0;
            nm = (m_mode == S_IDLE && en) ? S_RUN : S_IDLE;
        end else if (tr || mr || br) begin
            ifl = 1; exl = 1; nm = S_FLUSH; nl = FC;
        end else if (m_mode == S_RUN) begin
            if (lh) begin st = 1; exl = 1; end
            else if (jh) begin st = 1; nm = S_JWAIT; nw = 0; end
            else if (!rdy) begin st = 1; ifl = 1; nm = S_MWAIT; end
        end else if (m_mode == S_FLUSH) begin
            ifl = 1; msk = 1; nl = m_left - 1;
            if (nl == 0) nm = rdy ? S_RUN : S_MWAIT;
        end else if (m_mode == S_JWAIT) begin
            if (lh) begin st = 1; exl = 1; end
            else if (!jh) nm = S_RUN;
            else if (m_wait >= JM) begin msk = 1; nm = S_RUN; end
            else begin st = 1; nw = m_wait + 1; end
        end else begin
            if (!rdy) begin st = 1; ifl = 1; end
            else nm = S_RUN;
        end
        #1;
        check("pc_stall", 8'(pc_stall), 8'(st));
        check("if_id_flush", 8'(if_id_flush), 8'(ifl));
        check("id_ex_flush", 8'(id_ex_flush), 8'(exl));
        check("predt_mask", 8'(predt_mask), 8'(msk));
        check("ctrl_state", 8'(ctrl_state), 8'(m_mode));
        check("mispredict_cnt", mispredict_cnt, 8'(m_mis));
        @(posedge clk);
        if (en && br && m_mis < 255) m_mis++;
        m_mode = nm; m_left = nl; m_wait = nw;
        #1;
    endtask

    initial begin
        @(posedge clk); #1;
        check("reset_state", 8'(ctrl_state), 8'(S_IDLE));
        check("reset_pc_stall", 8'(pc_stall), 8'd1);
        check("reset_flushes", 8'({if_id_flush, id_ex_flush, predt_mask}), 8'd0);
        rst_n = 1'b1;
        // start-up, then a branch redirect with two bubble cycles
        cycle(1, 0, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 1);
        check("run_after_enable", 8'(ctrl_state), 8'(S_RUN));
        cycle(1, 0, 0, 1, 0, 0, 1);
        repeat (3) cycle(1, 0, 0, 0, 0, 0, 1);
        check("mispredict_one", mispredict_cnt, 8'd1);
        // JALR operand never ready: four stalls then one masked cycle
        repeat (6) cycle(1, 0, 0, 0, 0, 1, 1);
        cycle(1, 0, 0, 0, 0, 0, 1);
        // trap with load hazard while in JWAIT
        cycle(1, 0, 0, 0, 0, 1, 1);
        cycle(1, 1, 0, 0, 1, 1, 1);
        repeat (3) cycle(1, 0, 0, 0, 0, 0, 1);
        // trap and branch together: one redirect, one count
        cycle(1, 1, 0, 1, 0, 0, 1);
        repeat (3) cycle(1, 0, 0, 0, 0, 0, 1);
        // imem not ready for three cycles
        repeat (3) cycle(1, 0, 0, 0, 0, 0, 0);
        repeat (2) cycle(1, 0, 0, 0, 0, 0, 1);
        // redirect restarts an in-progress flush; flush ending into MWAIT
        cycle(1, 0, 1, 0, 0, 0, 1);
        cycle(1, 0, 1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 1);
        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 99) < 97, $urandom_range(0, 99) < 3,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 6,
                  $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 25,
                  $urandom_range(0, 99) < 85);
        end
        // saturation of the mispredict counter
        for (int i = 0; i < 300; i++) begin
            cycle(1, 0, 0, 1, 0, 0, 1);
            cycle(1, 0, 0, 0, 0, 0, 1);
        end
        check("mispredict_saturated", mispredict_cnt, 8'd255);
        // asynchronous reset in the middle of a flush
        cycle(1, 0, 0, 1, 0, 0, 1);
        check("in_flush", 8'(ctrl_state), 8'(S_FLUSH));
        rst_n = 1'b0;
        #2;
        check("async_state", 8'(ctrl_state), 8'(S_IDLE));
        check("async_cnt", mispredict_cnt, 8'd0);
        check("async_pc_stall", 8'(pc_stall), 8'd1);
        check("async_flushes", 8'({if_id_flush, id_ex_flush, predt_mask}), 8'd0);
        m_mode = S_IDLE; m_left = 0; m_wait = 0; m_mis = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) cycle(1, 0, 0, 0, 0, 0, 1);
        check("post_reset_run", 8'(ctrl_state), 8'(S_RUN));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
